// File: rtl/fp32_pkg.sv
// ============================================================================
// fp32_pkg : IEEE754 single-precision constants and integer-power FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package fp32_pkg;

    localparam int          EXP_BIAS = 127;
    localparam int          EXP_MAX  = 255;
    localparam logic [31:0] FP_ONE   = 32'h3F80_0000;
    localparam logic [31:0] FP_PINF  = 32'h7F80_0000;
    localparam int          QNAN_BIT = 22;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        FIN  = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/fp_pow_int_seq_if.sv
// ============================================================================
// fp_pow_int_seq_if : start/done request and result bus of the power unit
// Rev 1.0
// ============================================================================
`default_nettype none

interface fp_pow_int_seq_if #(
    parameter int K_W = 5
) ();

    logic           start;
    logic [31:0]    X;
    logic [K_W-1:0] K;
    logic [31:0]    result;
    logic           overflow;
    logic           underflow;
    logic           busy;
    logic           done;

    modport master (
        output start, X, K,
        input  result, overflow, underflow, busy, done
    );

    modport slave (
        input  start, X, K,
        output result, overflow, underflow, busy, done
    );

endinterface

`default_nettype wire

// File: rtl/mant_mul_seq.sv
// ============================================================================
// mant_mul_seq : 24x24 shift-add mantissa multiplier, one multiplier bit/step
// Rev 1.0
// ============================================================================
`default_nettype none

module mant_mul_seq (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        i_load,
    input  wire logic        i_step,
    input  wire logic [23:0] i_a,
    input  wire logic [23:0] i_b,
    output logic      [47:0] o_product
);

    logic [23:0] mcand_q, mcand_d;
    logic [23:0] mplier_q, mplier_d;
    logic [47:0] prod_q, prod_d;
    logic [24:0] w_sum;

    // LSB-first: add into the upper half, then shift the whole product right
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        w_sum    = {1'b0, prod_q[47:24]} + {1'b0, (mplier_q[0] ? mcand_q : 24'd0)};
        if (i_load) begin
            mcand_d  = i_a;
            mplier_d = i_b;
            prod_d   = 48'd0;
        end else if (i_step) begin
            prod_d   = {w_sum, prod_q[23:1]};
            mplier_d = {1'b0, mplier_q[23:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= 24'd0;
            mplier_q <= 24'd0;
            prod_q   <= 48'd0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end

    assign o_product = prod_q;

endmodule

`default_nettype wire

// File: rtl/fp_pow_int_seq.sv
// ============================================================================
// fp_pow_int_seq : sequential fp32 X^K by repeated mantissa multiplication.
// Optional FP_POW_ROUND_NEAREST_EN: round-to-nearest-even instead of truncate.
// Rev 1.0
// ============================================================================
`default_nettype none

module fp_pow_int_seq
    import fp32_pkg::*;
#(
    parameter int K_W       = 5,
    parameter int MUL_STEPS = 24
) (
    input  wire logic       CLK,
    input  wire logic       RST,
    fp_pow_int_seq_if.slave bus
);

    localparam int STEP_W = $clog2(MUL_STEPS + 1);

    state_e             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic [31:0]        result_q, result_d;
    logic               sign_q, sign_d;
    logic [22:0]        x_frac_q, x_frac_d;
    logic [7:0]         x_exp_q, x_exp_d;
    logic [7:0]         acc_exp_q, acc_exp_d;
    logic [K_W-1:0]     rem_q, rem_d;
    logic [STEP_W-1:0]  step_q, step_d;

    logic               mul_load, mul_step;
    logic [23:0]        mul_a, mul_b;
    logic [47:0]        product;

    logic               w_sign, w_hi, w_rnd_c, w_ovf, w_unf;
    logic [22:0]        w_frac_t, w_frac;
    logic [9:0]         w_exp;

    mant_mul_seq u_mul (
        .clk       (CLK),
        .rst_n     (RST),
        .i_load    (mul_load),
        .i_step    (mul_step),
        .i_a       (mul_a),
        .i_b       (mul_b),
        .o_product (product)
    );

    assign w_hi     = product[47];
    assign w_frac_t = w_hi ? product[46:24] : product[45:23];

`ifdef FP_POW_ROUND_NEAREST_EN
    logic        w_guard, w_sticky, w_round_up;
    logic [23:0] w_frac_r;
    assign w_guard    = w_hi ? product[23] : product[22];
    assign w_sticky   = w_hi ? (|product[22:0]) : (|product[21:0]);
    assign w_round_up = w_guard & (w_sticky | w_frac_t[0]);
    // A carry out leaves the fraction at zero, i.e. the renormalized 1.0
    assign w_frac_r   = {1'b0, w_frac_t} + {23'd0, w_round_up};
    assign w_rnd_c    = w_frac_r[23];
    assign w_frac     = w_frac_r[22:0];
`else
    logic unused_lsbs;
    assign unused_lsbs = ^product[22:0];
    assign w_rnd_c     = 1'b0;
    assign w_frac      = w_frac_t;
`endif

    // 10-bit two's complement so both overflow and underflow are visible
    assign w_exp = {2'b00, acc_exp_q} + {2'b00, x_exp_q} - 10'(EXP_BIAS)
                 + {9'd0, w_hi} + {9'd0, w_rnd_c};
    assign w_ovf = $signed(w_exp) >= $signed(10'(EXP_MAX));
    assign w_unf = $signed(w_exp) <= 10'sd0;

    assign w_sign = bus.X[31] & bus.K[0];

    always_comb begin
        state_d   = state_q;
        busy_d    = done_q ? 1'b0 : busy_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        result_d  = result_q;
        sign_d    = sign_q;
        x_frac_d  = x_frac_q;
        x_exp_d   = x_exp_q;
        acc_exp_d = acc_exp_q;
        rem_d     = rem_q;
        step_d    = step_q;
        mul_load  = 1'b0;
        mul_step  = 1'b0;
        mul_a     = {1'b1, w_frac};
        mul_b     = {1'b1, x_frac_q};

        case (state_q)
            IDLE: begin
                if (bus.start && !busy_q) begin
                    busy_d    = 1'b1;
                    ovf_d     = 1'b0;
                    unf_d     = 1'b0;
                    sign_d    = w_sign;
                    x_frac_d  = bus.X[22:0];
                    x_exp_d   = bus.X[30:23];
                    acc_exp_d = bus.X[30:23];
                    rem_d     = bus.K - K_W'(1);
                    step_d    = STEP_W'(MUL_STEPS);
                    state_d   = FIN;
                    if (bus.K == '0) begin
                        result_d = FP_ONE;
                    end else if (bus.X[30:23] == 8'd0) begin
                        result_d = {w_sign, 31'd0};
                    end else if (bus.X[30:23] == 8'hFF) begin
                        result_d = (bus.X[22:0] != 23'd0)
                                 ? {w_sign, 8'hFF, bus.X[22:0] | (23'd1 << QNAN_BIT)}
                                 : {w_sign, FP_PINF[30:0]};
                    end else if (bus.K == K_W'(1)) begin
                        result_d = bus.X;
                    end else begin
                        state_d  = MUL;
                        mul_load = 1'b1;
                        mul_a    = {1'b1, bus.X[22:0]};
                        mul_b    = {1'b1, bus.X[22:0]};
                    end
                end
            end
            MUL: begin
                mul_step = 1'b1;
                step_d   = step_q - STEP_W'(1);
                if (step_q == STEP_W'(1)) state_d = NORM;
            end
            NORM: begin
                if (w_ovf) begin
                    ovf_d    = 1'b1;
                    result_d = {sign_q, FP_PINF[30:0]};
                    state_d  = FIN;
                end else if (w_unf) begin
                    unf_d    = 1'b1;
                    result_d = {sign_q, 31'd0};
                    state_d  = FIN;
                end else begin
                    acc_exp_d = w_exp[7:0];
                    rem_d     = rem_q - K_W'(1);
                    if (rem_q == K_W'(1)) begin
                        result_d = {sign_q, w_exp[7:0], w_frac};
                        state_d  = FIN;
                    end else begin
                        mul_load = 1'b1;
                        step_d   = STEP_W'(MUL_STEPS);
                        state_d  = MUL;
                    end
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            result_q  <= 32'd0;
            sign_q    <= 1'b0;
            x_frac_q  <= 23'd0;
            x_exp_q   <= 8'd0;
            acc_exp_q <= 8'd0;
            rem_q     <= '0;
            step_q    <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            result_q  <= result_d;
            sign_q    <= sign_d;
            x_frac_q  <= x_frac_d;
            x_exp_q   <= x_exp_d;
            acc_exp_q <= acc_exp_d;
            rem_q     <= rem_d;
            step_q    <= step_d;
        end
    end

    assign bus.result    = result_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_pow_int_seq.sv
// ============================================================================
// tb_fp_pow_int_seq : directed vectors, scoreboard queue checked on done
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fp_pow_int_seq;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    fp_pow_int_seq_if #(.K_W(5)) bus ();

    fp_pow_int_seq #(.K_W(5), .MUL_STEPS(24)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

`ifdef FP_POW_ROUND_NEAREST_EN
    localparam logic [31:0] RND_EXP = 32'h4010_0002;
`else
    localparam logic [31:0] RND_EXP = 32'h4010_0001;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge CLK) begin
        exp_t e;
        if (RST && bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got result %h with no job pending", bus.result);
            end else begin
                e = sb.pop_front();
                check("result", bus.result, e.res);
                check("overflow", {31'd0, bus.overflow}, {31'd0, e.ovf});
                check("underflow", {31'd0, bus.underflow}, {31'd0, e.unf});
            end
        end
    end

    task automatic run_job(input logic [31:0] x, input logic [4:0] k, input logic [31:0] r,
                           input logic ov, input logic un, input int lat, input bit glitch);
        int got;
        bit busy_ok;
        @(negedge CLK);
        bus.start = 1'b1;
        bus.X     = x;
        bus.K     = k;
        sb.push_back('{r, ov, un});
        @(posedge CLK);
        #1;
        bus.start = 1'b0;
        bus.X     = 32'hDEAD_BEEF;
        bus.K     = 5'd7;
        got     = 0;
        busy_ok = 1'b1;
        for (int c = 1; c <= 800 && got == 0; c++) begin
            @(posedge CLK);
            #1;
            if (glitch && c == 5) begin
                bus.start = 1'b1;
                bus.X     = 32'h1234_5678;
                bus.K     = 5'd0;
            end
            if (glitch && c == 6) bus.start = 1'b0;
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.done) got = c;
        end
        check("latency", 32'(got), 32'(lat));
        check("busy", {31'd0, busy_ok}, 32'd1);
        repeat (3) @(posedge CLK);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.X     = 32'd0;
        bus.K     = 5'd0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_result", bus.result, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;

        run_job(32'h4000_0000, 5'd3,  32'h4100_0000, 1'b0, 1'b0, 51,  1'b0);
        run_job(32'hBFC0_0000, 5'd2,  32'h4010_0000, 1'b0, 1'b0, 26,  1'b0);
        run_job(32'hBFC0_0000, 5'd3,  32'hC058_0000, 1'b0, 1'b0, 51,  1'b0);
        run_job(32'h1234_5678, 5'd0,  32'h3F80_0000, 1'b0, 1'b0, 1,   1'b0);
        run_job(32'hFFC0_0000, 5'd4,  32'h7FC0_0000, 1'b0, 1'b0, 1,   1'b0);
        run_job(32'hFF80_0000, 5'd3,  32'hFF80_0000, 1'b0, 1'b0, 1,   1'b0);
        run_job(32'h0000_0000, 5'd5,  32'h0000_0000, 1'b0, 1'b0, 1,   1'b0);
        run_job(32'hC049_0FDB, 5'd1,  32'hC049_0FDB, 1'b0, 1'b0, 1,   1'b0);
        run_job(32'h7F00_0000, 5'd2,  32'h7F80_0000, 1'b1, 1'b0, 26,  1'b0);
        run_job(32'h7F00_0000, 5'd31, 32'h7F80_0000, 1'b1, 1'b0, 26,  1'b0);
        run_job(32'h0080_0000, 5'd2,  32'h0000_0000, 1'b0, 1'b1, 26,  1'b0);
        run_job(32'h3FC0_0001, 5'd2,  RND_EXP,       1'b0, 1'b0, 26,  1'b0);
        run_job(32'h3F80_0000, 5'd31, 32'h3F80_0000, 1'b0, 1'b0, 751, 1'b0);
        run_job(32'h4000_0000, 5'd3,  32'h4100_0000, 1'b0, 1'b0, 51,  1'b1);

        // Abort a K=3 job at cycle 10 with an asynchronous reset
        @(negedge CLK);
        bus.start = 1'b1;
        bus.X     = 32'h4000_0000;
        bus.K     = 5'd3;
        @(posedge CLK);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        check("abort_result", bus.result, 32'd0);
        check("abort_ovf", {31'd0, bus.overflow}, 32'd0);
        check("abort_unf", {31'd0, bus.underflow}, 32'd0);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        run_job(32'hBFC0_0000, 5'd3, 32'hC058_0000, 1'b0, 1'b0, 51, 1'b0);

        repeat (60) @(posedge CLK);
        check("pending_jobs", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fp_pow_int_seq.md
Name: fp_pow_int_seq

Overview:
- Sequential IEEE754 single-precision integer-power unit: computes X^K for unsigned integer K by repeated mantissa multiplication.
- Sits directly upstream of the divider in the Nroot Newton iteration. Its result x^(n-1) is the divider's B operand.
- Uses a start/done handshake. Rounding is by truncation, matching the divider.

Parameters:
- K_W, 5, width of exponent-count input K (K range 0..2^K_W-1)
- MUL_STEPS, 24, shift-add iterations per mantissa multiply (fixed to mantissa width incl. hidden bit)

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- X  input  32  IEEE754 base operand
- K  input  K_W  integer power
- result  output  32  IEEE754 X^K, held until next accepted start
- overflow  output  1  result exponent exceeded 254; held with result
- underflow  output  1  result exponent fell below 1 (flushed to zero); held with result
- busy  output  1  high from cycle after accepted start through done cycle
- done  output  1  one-cycle pulse, result valid

Behaviour:
- Reset (RST low, asynchronous): state IDLE. result=0, overflow=0, underflow=0, busy=0, done=0.
- Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, MUL, NORM, FIN.
- IDLE: on start=1, latch X and K, clear flags, then branch:
  - K==0 -> FIN with result 0x3F800000 (any X, incl. NaN/Inf)
  - X exp==0 (zero/denormal, flushed) -> FIN with ±0
  - X exp==255 -> FIN with NaN passed through (frac forced nonzero, quiet bit set) or Inf
  - K==1 -> FIN with result X
  - otherwise -> MUL with acc=X mantissa, acc_exp=X exp, remaining=K-1, step=MUL_STEPS
- Sign of every result = X[31] & K[0].
- MUL:
  - 24-bit x 24-bit shift-add into 48-bit product, one multiplier bit per cycle.
  - Exactly MUL_STEPS cycles, then NORM.
- NORM (1 cycle):
  - If product[47]: mantissa=product[46:24], exp += 1; else mantissa=product[45:23].
  - Exponent held in 10-bit signed: e = acc_exp + Xexp - 127 (+1).
  - e>=255 -> overflow=1, result ±Inf (0x7F800000|sign), go to FIN.
  - e<=0 -> underflow=1, result ±0, go to FIN.
  - Else decrement remaining; remaining==0 -> FIN, otherwise -> MUL.
- FIN: done=1 for one cycle, result/flags registered and stable; next state IDLE.
- Latency from accepted start edge to done: 1 cycle for special cases and K<=1; (K-1)*25+1 cycles otherwise (K=31 -> 751).
- Early overflow/underflow terminates the remaining multiplies.
- start while busy or in FIN is ignored. X/K changes after acceptance have no effect.
- A start in the cycle after done is accepted.

Optional Feature:
- Macro FP_POW_ROUND_NEAREST_EN.
- Defined:
  - Each NORM applies round-to-nearest-even using guard bit plus OR of all lower product bits as sticky.
  - A rounding carry out of the mantissa renormalizes (mantissa=0, exp+1) and is included in the overflow check.
  - NORM remains 1 cycle.
- Undefined: truncation, matching the divider.

Decomposition:
- Package fp32_pkg holds:
  - constants EXP_BIAS=127, EXP_MAX=255, FP_ONE=32'h3F800000, FP_PINF=32'h7F800000, QNAN_BIT=22
  - typedef for state enum {IDLE,MUL,NORM,FIN}
- One sub-module, mant_mul_seq: 24x24 shift-add multiplier with load/step inputs and a 48-bit product output; the FSM owns the step counter.

Test Plan:
- X=0x40000000 (2.0), K=3 -> result 0x41000000, flags 0, done exactly 51 cycles after start edge, busy high for those cycles.
- X=0xBFC00000 (-1.5): K=2 -> 0x40100000; K=3 -> 0xC0580000 (sign follows K parity).
- X=0x12345678, K=0 -> 0x3F800000 done after 1 cycle; X=0xFFC00000 NaN, K=4 -> NaN out; X=0x00000000, K=5 -> 0x00000000.
- X=0x7F000000, K=2 -> overflow=1, result 0x7F800000; X=0x00800000, K=2 -> underflow=1, result 0x00000000.
- X=0x3FC00001, K=2 -> 0x40100001 with macro undefined; 0x40100002 with FP_POW_ROUND_NEAREST_EN defined.
- start pulsed during MUL ignored (result unchanged, single done); RST low at cycle 10 of K=3 job -> all outputs 0, no done; new start after release completes normally.
